// File: rtl/rr_output_arbiter.sv
// Round-robin arbiter for one router output port: next-hop decode, rotating priority, crossbar select.
// Optional wormhole packet lock via RR_ARB_PKT_LOCK_EN (undefined: per-flit arbitration).
module rr_output_arbiter #(
    parameter int unsigned                NUM_PORTS    = 5,
    parameter int unsigned                ADDR_W       = 3,
    parameter logic [ADDR_W-1:0]          PORT_ID      = ADDR_W'(2),
    parameter logic [NUM_PORTS-1:0]       EXCLUDE_MASK = NUM_PORTS'(4),
    parameter int unsigned                IDX_W        = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   nexthop_addr_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS-1:0]          req_tail_i,
    input  logic                          out_ready_i,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          grant_valid_o,
    output logic                          xfer_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       ptr_q;
    logic [NUM_PORTS-1:0]   elig;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       ptr_next;
    logic [IDX_W-1:0]       cand;
    logic                   load;
    logic                   rel_c;

    // Per-port eligibility: valid, addressed to this output, not excluded
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            elig[k] = req_valid_i[k]
                    & (nexthop_addr_i[k*ADDR_W +: ADDR_W] == PORT_ID)
                    & ~EXCLUDE_MASK[k];
        end
    end

    // Rotating-priority search starting at ptr_q, wrapping modulo NUM_PORTS
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IDX_W'((32'(ptr_q) + 32'(i)) % NUM_PORTS);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        ptr_next = IDX_W'((32'(win_idx) + 32'd1) % NUM_PORTS);
    end

    // Flit moves only when the held port has data and downstream accepts; never in a reset cycle
    assign xfer_o = grant_valid_o & (|(grant_o & req_valid_i)) & out_ready_i & reset;

`ifdef RR_ARB_PKT_LOCK_EN
    assign rel_c = xfer_o & (|(grant_o & req_tail_i));
`else
    // Tail marker has no meaning when every flit re-arbitrates
    logic unused_tail;
    assign unused_tail = ^req_tail_i;
    assign rel_c       = xfer_o;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    load    = 1'b1;
                end
            end
            GRANT: begin
                if (rel_c) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_o       <= '0;
            grant_idx_o   <= '0;
            grant_valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_o       <= NUM_PORTS'(1) << win_idx;
                grant_idx_o   <= win_idx;
                grant_valid_o <= 1'b1;
                ptr_q         <= ptr_next;
            end else if (state_d == IDLE) begin
                grant_o       <= '0;
                grant_idx_o   <= '0;
                grant_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Bench for rr_output_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural round-robin model.
module tb_rr_output_arbiter;

    localparam int unsigned N       = 5;
    localparam int unsigned AW      = 3;
    localparam int unsigned IW      = 3;
    localparam int unsigned PID     = 2;
    localparam int unsigned EXCL    = 2;
`ifdef RR_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    v = '0;
    logic [N-1:0]    t = '0;
    logic [AW-1:0]   addr [N];
    logic            rdy = 1'b0;
    logic [N*AW-1:0] nexthop;
    logic [N-1:0]    grant_o;
    logic [IW-1:0]   grant_idx_o;
    logic            grant_valid_o;
    logic            xfer_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        nexthop = '0;
        for (int k = 0; k < N; k++) nexthop[k*AW +: AW] = addr[k];
    end

    rr_output_arbiter dut (
        .clk            (clk),
        .reset          (rst_n),
        .nexthop_addr_i (nexthop),
        .req_valid_i    (v),
        .req_tail_i     (t),
        .out_ready_i    (rdy),
        .grant_o        (grant_o),
        .grant_idx_o    (grant_idx_o),
        .grant_valid_o  (grant_valid_o),
        .xfer_o         (xfer_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // m: which ports carry an address matching this output (others get a non-matching code)
    task automatic set_in(input logic [N-1:0] vv, input logic [N-1:0] tt,
                          input logic [N-1:0] m, input logic rr);
        v   = vv;
        t   = tt;
        rdy = rr;
        for (int k = 0; k < N; k++) addr[k] = m[k] ? AW'(PID) : AW'(5);
    endtask

    // Behavioural model: held port index, validity and rotating priority pointer as plain ints
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_ptr   = 0;

    function automatic bit eligible(input int k);
        return v[k] && (addr[k] == AW'(PID)) && (k != EXCL);
    endfunction

    initial begin
        @(posedge clk);
        forever begin
            bit exp_xfer;
            bit rel;
            bit found;
            @(negedge clk);
            exp_xfer = rst_n && m_valid && v[m_idx] && rdy;
            chk("grant_valid", 32'(grant_valid_o), 32'(m_valid));
            chk("grant_idx", 32'(grant_idx_o), m_valid ? m_idx : 0);
            chk("grant_onehot", 32'(grant_o), m_valid ? (32'd1 << m_idx) : 32'd0);
            chk("xfer", 32'(xfer_o), 32'(exp_xfer));
            if (!rst_n) begin
                m_valid = 1'b0;
                m_idx   = 0;
                m_ptr   = 0;
            end else begin
                rel = exp_xfer && (!LOCK || t[m_idx]);
                if (!m_valid || rel) begin
                    found = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        int c;
                        c = (m_ptr + i) % N;
                        if (!found && eligible(c)) begin
                            found = 1'b1;
                            m_idx = c;
                        end
                    end
                    m_valid = found;
                    if (found) m_ptr = (m_idx + 1) % N;
                    else m_idx = 0;
                end
            end
        end
    end

    int fair_seq [7];
    int lock_seq [8];
    int sent1;

    initial begin
        for (int k = 0; k < N; k++) addr[k] = '0;
        fair_seq = '{1, 3, 4, 0, 1, 3, 4};
`ifdef RR_ARB_PKT_LOCK_EN
        lock_seq = '{1, 1, 1, 1, 1, 1, 1, 4};
`else
        lock_seq = '{1, 4, 4, 1, 1, 4, 4, 1};
`endif

        // Reset held with everything eligible
        rst_n = 1'b0;
        set_in(5'b11111, 5'b11111, 5'b11111, 1'b1);
        repeat (3) tick();
        chk("rst_valid", 32'(grant_valid_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_idx", 32'(grant_idx_o), 0);
        chk("rst_xfer", 32'(xfer_o), 0);
        rst_n = 1'b1;
        tick();
        chk("first_grant", 32'(grant_o), 32'b00001);
        chk("first_idx", 32'(grant_idx_o), 0);

        // Fairness with single-flit packets; port 2 never wins
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("fair_idx", 32'(grant_idx_o), fair_seq[i]);
            chk("fair_no_excl", 32'(grant_o[2]), 0);
        end

        // Address filter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_in(5'b11111, 5'b11111, 5'b00000, 1'b1);
        repeat (6) begin
            tick();
            chk("filter_valid", 32'(grant_valid_o), 0);
        end

        // Port 1 sends a 4-flit packet while port 4 requests, ready toggling
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_in(5'b10010, 5'b10000, 5'b11111, 1'b1);
        tick();
        sent1 = 0;
        for (int i = 0; i < 8; i++) begin
            logic r;
            r = (i % 2 == 0);
            set_in(5'b10000 | ((sent1 < 4) ? 5'b00010 : 5'b00000),
                   5'b10000 | ((sent1 == 3) ? 5'b00010 : 5'b00000), 5'b11111, r);
            chk("lock_idx", 32'(grant_idx_o), lock_seq[i]);
            chk("lock_valid", 32'(grant_valid_o), 1);
            if (lock_seq[i] == 1 && r) sent1++;
            tick();
        end

        // Pointer wrap: get ptr to 4 via port 3, then ports 0 and 4 compete
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_in(5'b01000, 5'b11111, 5'b11111, 1'b1);
        tick();
        chk("wrap_pre", 32'(grant_idx_o), 3);
        set_in(5'b11001, 5'b11111, 5'b11111, 1'b1);
        tick();
        chk("wrap_4", 32'(grant_idx_o), 4);
        set_in(5'b10001, 5'b11111, 5'b11111, 1'b1);
        tick();
        chk("wrap_0", 32'(grant_idx_o), 0);

        // Reset during flit 2 of a 3-flit packet
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_in(5'b00001, 5'b00000, 5'b11111, 1'b1);
        tick();
        chk("mid_grant", 32'(grant_o), 32'b00001);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_xfer", 32'(xfer_o), 0);
        tick();
        chk("mid_cleared", 32'(grant_valid_o), 0);
        chk("mid_grant0", 32'(grant_o), 0);
        rst_n = 1'b1;
        set_in(5'b00011, 5'b00000, 5'b11111, 1'b1);
        tick();
        chk("mid_ptr0", 32'(grant_idx_o), 0);

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] m;
            for (int k = 0; k < N; k++) m[k] = ($urandom_range(0, 3) != 0);
            set_in(N'($urandom), N'($urandom), m, $urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
